// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - chunk-serial adder/subtractor, CHUNK bits per clock, LS chunk first
// Subtraction is done as A + ~B + ~bin so one carry chain serves both modes.
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry_out,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_k;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_last;
  logic             w_msb_cin;

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int j = 0; j < NCH; j++) begin
      if (r_k == CW'(j)) begin
        w_a_chunk = r_a[j*CHUNK +: CHUNK];
        w_b_chunk = r_b[j*CHUNK +: CHUNK];
      end
    end
    w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
    w_msb_cin = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    w_last    = (r_k == CW'(NCH - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_next = S_RUN;
      S_RUN:   if (w_last)  w_next = S_DONE;
      S_DONE:  if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? ~i_carry_in : i_carry_in;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          for (int j = 0; j < NCH; j++) begin
            if (r_k == CW'(j)) r_s[j*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
          end
          r_carry <= w_sum[CHUNK];
          r_k     <= r_k + 1'b1;
          // Flags live in their own registers so they survive the next accept.
          if (w_last) begin
            r_cout <= w_sum[CHUNK];
            r_ovf  <= w_msb_cin ^ w_sum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_busy      = (r_state == S_RUN);
  assign o_valid     = (r_state == S_DONE);
  assign o_s         = r_s;
  assign o_carry_out = r_cout;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - scoreboard bench for seq_chunk_adder (8x1 and 16x4 instances)
module tb_seq_chunk_adder;

  typedef struct {
    logic [15:0] s;
    bit          cout;
    bit          ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       v8 = 1'b0, rdy8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       o_ready8, o_valid8, o_cout8, o_ovf8, o_busy8;
  logic [7:0] o_s8;

  logic        v16 = 1'b0, rdy16 = 1'b1, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        o_ready16, o_valid16, o_cout16, o_ovf16, o_busy16;
  logic [15:0] o_s16;

  exp_t q8[$];
  exp_t q16[$];
  exp_t cur8, cur16;
  bit   have8 = 1'b0, have16 = 1'b0;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(o_ready8),
    .i_a(a8), .i_b(b8), .i_carry_in(cin8), .i_sub(sub8),
    .o_valid(o_valid8), .i_ready(rdy8), .o_s(o_s8),
    .o_carry_out(o_cout8), .o_overflow(o_ovf8), .o_busy(o_busy8)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(o_ready16),
    .i_a(a16), .i_b(b16), .i_carry_in(cin16), .i_sub(sub16),
    .o_valid(o_valid16), .i_ready(rdy16), .o_s(o_s16),
    .o_carry_out(o_cout16), .o_overflow(o_ovf16), .o_busy(o_busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input bit cin, input bit sub,
                                output logic [15:0] s, output bit cout, output bit ovf);
    longint m  = longint'(1) << w;
    longint h  = m >> 1;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint c  = longint'(cin);
    longint r, sa, sb, sr;
    r    = sub ? (ua - ub - c) : (ua + ub + c);
    s    = 16'(r & (m - 1));
    cout = sub ? (ua >= ub + c) : (r >= m);
    sa   = (ua >= h) ? ua - m : ua;
    sb   = (ub >= h) ? ub - m : ub;
    sr   = sub ? (sa - sb - c) : (sa + sb + c);
    ovf  = (sr < -h) || (sr > h - 1);
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub);
    exp_t e;
    logic [15:0] s;
    bit co, ov;
    int n = 0;
    model(8, {8'h00, a}, {8'h00, b}, cin, sub, s, co, ov);
    e.s = s; e.cout = co; e.ovf = ov;
    @(posedge clk) #1;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; v8 = 1'b1;
    @(negedge clk);
    while (!o_ready8 && n < 100) begin @(negedge clk); n++; end
    if (!o_ready8) chk("op8_accept_timeout", 32'(o_ready8), 1);
    e.acc = cyc + 1;
    q8.push_back(e);
    @(posedge clk) #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub);
    exp_t e;
    logic [15:0] s;
    bit co, ov;
    int n = 0;
    model(16, a, b, cin, sub, s, co, ov);
    e.s = s; e.cout = co; e.ovf = ov;
    @(posedge clk) #1;
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1;
    @(negedge clk);
    while (!o_ready16 && n < 100) begin @(negedge clk); n++; end
    if (!o_ready16) chk("op16_accept_timeout", 32'(o_ready16), 1);
    e.acc = cyc + 1;
    q16.push_back(e);
    @(posedge clk) #1;
    v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    cin16 = 1'($urandom); sub16 = 1'($urandom);
  endtask

  task automatic drain(input bit wide);
    int n = 0;
    @(negedge clk);
    while (n < 300 && (wide ? (q16.size() != 0 || !o_ready16) : (q8.size() != 0 || !o_ready8))) begin
      @(negedge clk);
      n++;
    end
    if (wide) chk("drain16", 32'(q16.size() != 0 || !o_ready16), 0);
    else      chk("drain8", 32'(q8.size() != 0 || !o_ready8), 0);
  endtask

  task automatic reset_outputs_chk();
    chk("rst_ready8", 32'(o_ready8), 1);
    chk("rst_valid8", 32'(o_valid8), 0);
    chk("rst_busy8",  32'(o_busy8), 0);
    chk("rst_s8",     32'(o_s8), 0);
    chk("rst_cout8",  32'(o_cout8), 0);
    chk("rst_ovf8",   32'(o_ovf8), 0);
    chk("rst_ready16", 32'(o_ready16), 1);
    chk("rst_valid16", 32'(o_valid16), 0);
    chk("rst_s16",     32'(o_s16), 0);
  endtask

  // Monitors: pop on the rising edge of o_valid, then hold the result for every DONE cycle.
  initial begin
    bit pv = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid8) begin
        if (!pv) begin
          if (q8.size() == 0) begin
            chk("unexpected_valid8", 32'(o_valid8), 0);
            have8 = 1'b0;
          end else begin
            cur8 = q8.pop_front();
            have8 = 1'b1;
            chk("latency8", 32'(cyc - cur8.acc), 8);
          end
        end
        if (have8) begin
          chk("s8",    32'(o_s8),    32'(cur8.s));
          chk("cout8", 32'(o_cout8), 32'(cur8.cout));
          chk("ovf8",  32'(o_ovf8),  32'(cur8.ovf));
          chk("ready_in_done8", 32'(o_ready8), 0);
        end
      end
      pv = o_valid8;
    end
  end

  initial begin
    bit pv = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid16) begin
        if (!pv) begin
          if (q16.size() == 0) begin
            chk("unexpected_valid16", 32'(o_valid16), 0);
            have16 = 1'b0;
          end else begin
            cur16 = q16.pop_front();
            have16 = 1'b1;
            chk("latency16", 32'(cyc - cur16.acc), 4);
          end
        end
        if (have16) begin
          chk("s16",    32'(o_s16),    32'(cur16.s));
          chk("cout16", 32'(o_cout16), 32'(cur16.cout));
          chk("ovf16",  32'(o_ovf16),  32'(cur16.ovf));
        end
      end
      pv = o_valid16;
    end
  end

  initial begin
    int n;
    #1;
    reset_outputs_chk();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    op8(8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    op8(8'h05, 8'h07, 1'b0, 1'b1);
    op8(8'h80, 8'h01, 1'b0, 1'b1);
    op8(8'h09, 8'h03, 1'b1, 1'b1);
    drain(1'b0);

    // Backpressure: result held, i_valid pulse ignored while in DONE.
    rdy8 = 1'b0;
    op8(8'h3C, 8'h5A, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!o_valid8 && n < 50) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 32'(o_valid8), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1;
      v8 = (i == 2); a8 = 8'hAA; b8 = 8'h11;
      @(negedge clk);
      chk("bp_valid_held", 32'(o_valid8), 1);
      chk("bp_ready_low",  32'(o_ready8), 0);
    end
    @(posedge clk) #1;
    v8 = 1'b0; rdy8 = 1'b1;
    @(negedge clk);
    @(posedge clk) #1;
    chk("bp_ready_after", 32'(o_ready8), 1);
    chk("bp_valid_after", 32'(o_valid8), 0);
    chk("bp_s_retained",  32'(o_s8), 32'h96);

    // Asynchronous reset in the third RUN cycle aborts the operation.
    op8(8'hC3, 8'h21, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    q8.delete();
    have8 = 1'b0;
    reset_outputs_chk();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_valid_after_abort", 32'(o_valid8), 0);
    end
    op8(8'h12, 8'h34, 1'b0, 1'b0);
    drain(1'b0);

    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain(1'b1);

    for (int i = 0; i < 200; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised successor to the gate-level full adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, least-significant chunk first.
- Carry is held in a register between chunks.
- Has a valid/ready handshake on input and output; sits between operand registers and result consumers in the datapath labs.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.
CHUNK, 1, bits added per cycle; must divide WIDTH exactly (elaboration-time assertion).

Ports:
i_clk  in  1  clock, all state updates on rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_valid  in  1  operand request valid.
o_ready  out  1  block can accept an operand set.
i_a  in  WIDTH  operand A.
i_b  in  WIDTH  operand B.
i_carry_in  in  1  carry-in (add) / borrow-in (sub).
i_sub  in  1  0 = A+B+cin, 1 = A-B-bin.
o_valid  out  1  result valid.
i_ready  in  1  consumer accepts result.
o_s  out  WIDTH  sum/difference.
o_carry_out  out  1  carry out of MSB (sub mode: 1 = no borrow).
o_overflow  out  1  two's-complement signed overflow.
o_busy  out  1  computation in progress.

Behaviour:
- Reset (async, i_rst=1):
  - State becomes IDLE; internal registers are cleared.
  - Outputs: o_ready=1, o_valid=0, o_busy=0, o_s=0, o_carry_out=0, o_overflow=0.
  - Reset mid-operation aborts the operation; no result is ever presented.
- FSM states:
  - IDLE: o_ready=1. When i_valid=1, capture operands and go to RUN.
  - RUN: o_busy=1, o_ready=0.
  - DONE: o_valid=1, o_ready=0.
- Accept (IDLE and i_valid=1 at a clock edge):
  - Latch A.
  - Latch B' = i_sub ? ~i_b : i_b.
  - Initialise carry register = i_sub ? ~i_carry_in : i_carry_in.
  - Clear chunk counter.
- Input stability: i_a/i_b/i_carry_in/i_sub are sampled only at accept; later changes are ignored.
- RUN, each cycle:
  - Add chunk k of A and B' with the carry register.
  - Write the CHUNK-bit result into o_s bits [k*CHUNK +: CHUNK].
  - Update the carry register.
  - Increment k.
  - After chunk WIDTH/CHUNK-1, go to DONE.
- Latency: o_valid rises exactly WIDTH/CHUNK cycles after the accepting edge.
- Arithmetic:
  - Sub computes A + ~B + ~bin, which equals A - B - bin mod 2^WIDTH.
  - o_carry_out = final carry register value.
  - o_overflow = (carry into MSB) XOR (carry out of MSB); it is captured during the last chunk.
- o_s during RUN: o_s is internal, partially updated state and is not guaranteed meaningful while o_valid=0.
- DONE:
  - o_s, o_carry_out and o_overflow are held stable while o_valid=1.
  - On i_ready=1 go to IDLE; o_valid drops the next cycle.
  - o_ready=0 in DONE, so there is no same-cycle accept. Minimum initiation interval is WIDTH/CHUNK+2 cycles with i_ready tied high.
- Backpressure: with i_ready=0 in DONE, the block stays in DONE indefinitely with the result held; i_valid is ignored.
- i_valid while busy: ignored. The requester must hold i_valid until it sees o_ready=1 at a clock edge.
- Result retention: registers keep the last result after leaving DONE, until the next RUN overwrites them.

Test Plan:
1. WIDTH=8, CHUNK=1: A=0x00, B=0x00, cin=0, add -> o_valid exactly 8 cycles after accept; s=0x00, cout=0, ovf=0.
2. WIDTH=8, CHUNK=1: A=0xFF, B=0x01, cin=0 -> s=0x00, cout=1, ovf=0. Then A=0x7F, B=0x01 -> s=0x80, cout=0, ovf=1. Then A=0xFF, B=0xFF, cin=1 -> s=0xFF, cout=1, ovf=0.
3. WIDTH=8, sub: A=0x05, B=0x07, bin=0 -> s=0xFE, cout=0 (borrow). A=0x80, B=0x01 -> s=0x7F, ovf=1. A=0x09, B=0x03, bin=1 -> s=0x05, cout=1.
4. Backpressure: hold i_ready=0 for 5 cycles after o_valid -> result stable, o_ready=0, an i_valid pulse is ignored. Raise i_ready -> IDLE next cycle, o_ready=1.
5. Reset mid-RUN (cycle 3 of 8), i_rst asserted between clock edges -> outputs drop immediately to reset values and o_valid never rises. The next operation (0x12+0x34) gives s=0x46.
6. WIDTH=16, CHUNK=4: A=0xFFFF, B=0x0001 -> o_valid after 4 cycles; s=0x0000, cout=1. Randomised 1000 ops checked against a behavioural A±B±c model.
